sprite_line_scanout: RTL

- Read-side controller for the ping-pong sprite line buffer. Drives port B of the dual-port line buffer RAM.
- The buffer is split into two banks by the address MSB. The sprite renderer writes the next line into one bank through port A while this block scans the other bank out at pixel rate.
- Each location is cleared to transparent right after it is read, so the bank is blank when it becomes the write bank again.
- Outputs one pixel per pixel-enable, plus an opaque flag, to the video mixer.

---
 rtl/sprite_line_scanout_pkg.sv | 16 +
 rtl/sprite_line_scanout_if.sv | 31 +++
 rtl/sprite_line_scanout.sv | 105 ++++++++++
 3 files changed

// File: rtl/sprite_line_scanout_pkg.sv
// Shared sprite line buffer constants and the scan-out state encoding.
package sprite_line_scanout_pkg;

    localparam int unsigned LB_ADDR_WIDTH = 10;
    localparam int unsigned LB_DATA_WIDTH = 9;
    localparam int unsigned LINE_LEN      = 288;

    localparam logic [LB_DATA_WIDTH-1:0] CLEAR_VAL = 9'h000;

    typedef enum logic [1:0] {
        ST_DONE    = 2'd0,
        ST_SCAN_RD = 2'd1,
        ST_SCAN_WB = 2'd2
    } scan_state_e;

endpackage

// File: rtl/sprite_line_scanout_if.sv
// Port B of the dual-port sprite line buffer RAM.
interface sprite_line_scanout_if
    import sprite_line_scanout_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = LB_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = LB_DATA_WIDTH
);

    logic [ADDR_WIDTH-1:0] lb_address;
    logic [DATA_WIDTH-1:0] lb_data;
    logic                  lb_enable;
    logic                  lb_wren;
    logic [DATA_WIDTH-1:0] lb_q;

    modport master (
        output lb_address,
        output lb_data,
        output lb_enable,
        output lb_wren,
        input  lb_q
    );

    modport slave (
        input  lb_address,
        input  lb_data,
        input  lb_enable,
        input  lb_wren,
        output lb_q
    );

endinterface

// File: rtl/sprite_line_scanout.sv
// Ping-pong sprite line buffer read side: scans one bank out at pixel rate
// and clears each location right after it is read.
module sprite_line_scanout #(
    parameter int unsigned             ADDR_WIDTH = sprite_line_scanout_pkg::LB_ADDR_WIDTH,
    parameter int unsigned             DATA_WIDTH = sprite_line_scanout_pkg::LB_DATA_WIDTH,
    parameter int unsigned             LINE_LEN   = sprite_line_scanout_pkg::LINE_LEN,
    parameter logic [DATA_WIDTH-1:0]   CLEAR_VAL  = sprite_line_scanout_pkg::CLEAR_VAL
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ce_pix,
    input  logic                  line_start,
    output logic                  rd_bank,
    output logic                  wr_bank,
    output logic [DATA_WIDTH-1:0] pix_out,
    output logic                  pix_opaque,
    output logic                  pix_valid,
    sprite_line_scanout_if.master lb
);

    import sprite_line_scanout_pkg::*;

    localparam int unsigned XW = ADDR_WIDTH - 1;
    localparam logic [XW-1:0] X_LAST = XW'(LINE_LEN - 1);

    scan_state_e           state, state_n;
    logic [XW-1:0]         x, x_n;
    logic                  bank_n;
    logic [DATA_WIDTH-1:0] pix_n;
    logic                  opaque_n;
    logic                  valid_n;
    logic                  rd_req;

    // State, scan position, bank select and pixel output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_DONE;
            x          <= '0;
            rd_bank    <= 1'b0;
            pix_out    <= CLEAR_VAL;
            pix_opaque <= 1'b0;
            pix_valid  <= 1'b0;
        end else begin
            state      <= state_n;
            x          <= x_n;
            rd_bank    <= bank_n;
            pix_out    <= pix_n;
            pix_opaque <= opaque_n;
            pix_valid  <= valid_n;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_n  = state;
        x_n      = x;
        bank_n   = rd_bank;
        pix_n    = pix_out;
        opaque_n = pix_opaque;
        valid_n  = 1'b0;
        rd_req   = 1'b0;

        case (state)
            ST_SCAN_RD: begin
                if (ce_pix) begin
                    rd_req  = 1'b1;
                    state_n = ST_SCAN_WB;
                end
            end
            ST_SCAN_WB: begin
                pix_n    = lb.lb_q;
                opaque_n = (lb.lb_q != CLEAR_VAL);
                valid_n  = 1'b1;
                if (x == X_LAST) begin
                    x_n     = '0;
                    state_n = ST_DONE;
                end else begin
                    x_n     = x + XW'(1);
                    state_n = ST_SCAN_RD;
                end
            end
            ST_DONE: begin
                state_n = ST_DONE;
            end
            default: begin
                state_n = ST_DONE;
            end
        endcase

        // A new line overrides the normal transition; the current cycle's
        // RAM access still completes because it is decoded from state.
        if (line_start) begin
            state_n = ST_SCAN_RD;
            x_n     = '0;
            bank_n  = ~rd_bank;
        end
    end

    assign wr_bank       = ~rd_bank;
    assign lb.lb_address = {rd_bank, x};
    assign lb.lb_data    = CLEAR_VAL;
    assign lb.lb_wren    = (state == ST_SCAN_WB);
    assign lb.lb_enable  = rd_req | (state == ST_SCAN_WB);

endmodule
